// File: rtl/abacus_pkg.sv
// ---------------------------------------------------------------------------
// abacus_pkg
// Shared definitions for the abacus profiler blocks:
//   - abacus_state_e : state encoding of the snapshot reader FSM
//   - AXI_RESP_*     : AXI-Lite response codes
//   - PROF_*_OFFSET  : profiler register map offsets
//   - reg_addr()     : byte address of the n-th 32-bit register after a base
// ---------------------------------------------------------------------------
package abacus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_AR   = 3'd1,
        ST_R    = 3'd2,
        ST_OUT  = 3'd3,
        ST_DONE = 3'd4
    } abacus_state_e;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    // Profiler register map, relative to the profiler base address.
    localparam logic [31:0] PROF_INSTR_UNIT_OFFSET = 32'h0000_0100;
    localparam logic [31:0] PROF_CACHE_UNIT_OFFSET = 32'h0000_0200;
    localparam logic [31:0] PROF_ENABLE_OFFSET     = 32'h0000_0004;
    localparam logic [31:0] PROF_ENABLE2_OFFSET    = 32'h0000_0008;

    // Word index -> byte address; wraps modulo 2^32 by construction.
    function automatic logic [31:0] reg_addr(input logic [31:0] base,
                                             input logic [7:0]  idx);
        return base + {22'd0, idx, 2'b00};
    endfunction

endpackage

// File: rtl/abacus_snapshot_reader.sv
// ---------------------------------------------------------------------------
// abacus_snapshot_reader
// Reads NUM_REGS consecutive 32-bit counter registers over AXI-Lite, starting
// at BASE_ADDR, and forwards each word on a valid/ready stream together with
// its register index and a last-word flag. One read is outstanding at a time.
//
// Optional feature: define ABACUS_SNAPSHOT_TIMEOUT_EN to compile in a per-
// transaction timeout (adds the 'timeout' output port).
//
// Ports
//   aclk, rst                      clock, asynchronous active-high reset
//   start                          request a snapshot (sampled in IDLE only)
//   busy, done, error              status; error is sticky per snapshot
//   m_araddr/m_arvalid/m_arready   AXI-Lite read address channel
//   m_rdata/m_rresp/m_rvalid/m_rready  AXI-Lite read data channel
//   out_data/out_index/out_last    snapshot word, register index, final flag
//   out_valid/out_ready            output stream handshake
//   timeout                        (macro only) sticky timeout flag
// ---------------------------------------------------------------------------
module abacus_snapshot_reader
    import abacus_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR      = 32'hF003_0100,
    parameter int          NUM_REGS       = 11,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  logic        aclk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [31:0] m_araddr,
    output logic        m_arvalid,
    input  logic        m_arready,
    input  logic [31:0] m_rdata,
    input  logic [1:0]  m_rresp,
    input  logic        m_rvalid,
    output logic        m_rready,
    output logic [31:0] out_data,
    output logic [7:0]  out_index,
    output logic        out_last,
    output logic        out_valid,
    input  logic        out_ready
`ifdef ABACUS_SNAPSHOT_TIMEOUT_EN
    ,
    output logic        timeout
`endif
);

    localparam logic [7:0] LAST_IDX = 8'(NUM_REGS - 1);

    abacus_state_e state_q, state_d;
    logic [7:0]    index_q, index_d;
    logic [31:0]   data_q,  data_d;
    logic          error_q, error_d;
    logic          is_last;

    assign is_last = (index_q == LAST_IDX);

`ifdef ABACUS_SNAPSHOT_TIMEOUT_EN
    // Counter only has to reach TIMEOUT_CYCLES-1.
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] CNT_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] cnt_q, cnt_d;
    logic          timeout_q, timeout_d;
`else
    // Parameter kept for interface compatibility; no timeout logic in this build.
    logic timeout_param_unused;
    assign timeout_param_unused = (TIMEOUT_CYCLES != 0);
`endif

    // -----------------------------------------------------------------------
    // Next-state / output logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        index_d   = index_q;
        data_d    = data_q;
        error_d   = error_q;
        m_arvalid = 1'b0;
        m_rready  = 1'b0;
        out_valid = 1'b0;
        done      = 1'b0;
`ifdef ABACUS_SNAPSHOT_TIMEOUT_EN
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_AR;
                    index_d = 8'd0;
                    error_d = 1'b0;
`ifdef ABACUS_SNAPSHOT_TIMEOUT_EN
                    cnt_d     = '0;
                    timeout_d = 1'b0;
`endif
                end
            end

            ST_AR: begin
                m_arvalid = 1'b1;
                if (m_arready) begin
                    state_d = ST_R;
`ifdef ABACUS_SNAPSHOT_TIMEOUT_EN
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    // Give up on the slave; it needs a reset before reuse.
                    state_d   = ST_DONE;
                    error_d   = 1'b1;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + TW'(1);
`endif
                end
            end

            ST_R: begin
                m_rready = 1'b1;
                if (m_rvalid) begin
                    // Error responses are still forwarded; only flagged.
                    data_d  = m_rdata;
                    error_d = error_q | (m_rresp != AXI_RESP_OKAY);
                    state_d = ST_OUT;
`ifdef ABACUS_SNAPSHOT_TIMEOUT_EN
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = ST_DONE;
                    error_d   = 1'b1;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + TW'(1);
`endif
                end
            end

            ST_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (is_last) begin
                        state_d = ST_DONE;
                    end else begin
                        index_d = index_q + 8'd1;
                        state_d = ST_AR;
`ifdef ABACUS_SNAPSHOT_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                    end
                end
            end

            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge aclk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            index_q <= 8'd0;
            data_q  <= 32'd0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            data_q  <= data_d;
            error_q <= error_d;
        end
    end

`ifdef ABACUS_SNAPSHOT_TIMEOUT_EN
    always_ff @(posedge aclk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`endif

    // -----------------------------------------------------------------------
    // Outputs derived from registered state
    // -----------------------------------------------------------------------
    // Address only driven while the request is presented, so it reads 0 in
    // reset and between requests.
    assign m_araddr  = (state_q == ST_AR) ? reg_addr(BASE_ADDR, index_q) : 32'd0;
    assign out_data  = data_q;
    assign out_index = index_q;
    assign out_last  = (state_q == ST_OUT) && is_last;
    assign busy      = (state_q != ST_IDLE);
    assign error     = error_q;

endmodule

// File: doc/abacus_snapshot_reader.md
ABACUS_SNAPSHOT_READER -- requirements
Module: abacus_snapshot_reader

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'hF0030100, byte address of first counter register read.
REQ-002 SHALL have parameter NUM_REGS, default 11, number of consecutive 32-bit registers read per snapshot (legal 1..256).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255, per-transaction wait limit (used only with REQ-030).
REQ-004 aclk  input  1  clock; all logic on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 start  input  1  request one snapshot; sampled in IDLE only.
REQ-007 busy  output  1  high from cycle after accepted start until return to IDLE.
REQ-008 done  output  1  one-cycle pulse at snapshot end.
REQ-009 error  output  1  sticky: some read in current snapshot returned rresp != 2'b00; valid with done.
REQ-010 m_araddr  output  32  AXI-Lite read address.
REQ-011 m_arvalid  output  1 / m_arready  input  1  read address handshake.
REQ-012 m_rdata  input  32 / m_rresp  input  2 / m_rvalid  input  1 / m_rready  output  1  read data channel.
REQ-013 out_data  output  32 / out_index  output  8 / out_last  output  1  snapshot word, its register index, final-word flag.
REQ-014 out_valid  output  1 / out_ready  input  1  output stream handshake.

Function
REQ-015 SHALL implement states IDLE, AR, R, OUT, DONE.
REQ-016 IDLE: start=1 -> AR, index cleared to 0, error cleared; start in any other state SHALL be ignored.
REQ-017 AR: m_arvalid=1, m_araddr=BASE_ADDR+4*index (32-bit wrap), both stable until m_arvalid&m_arready; then -> R.
REQ-018 R: m_rready=1; on m_rvalid capture m_rdata into out_data, OR (m_rresp!=0) into error, -> OUT.
REQ-019 m_arvalid and m_rready SHALL never be high in the same cycle; at most one read outstanding.
REQ-020 OUT: out_valid=1, out_index=index, out_last=(index==NUM_REGS-1); data/index/last held stable until out_valid&out_ready.
REQ-021 OUT handshake: if out_last -> DONE, else index+1 and -> AR.
REQ-022 DONE: done=1 for exactly one cycle, -> IDLE; error retains value until next accepted start.
REQ-023 Minimum latency per word with arready/rvalid/out_ready tied high: 3 cycles (AR, R, OUT); whole snapshot 3*NUM_REGS+1 cycles from start-accept edge to done.
REQ-024 Error response data SHALL still be forwarded on the stream; snapshot SHALL NOT abort on rresp error.
REQ-025 busy = (state != IDLE).

Reset
REQ-026 rst SHALL force state IDLE immediately, including mid-transaction, with no completion of outstanding reads.
REQ-027 During and after reset: m_arvalid, m_rready, out_valid, out_last, done, busy, error = 0; m_araddr, out_data, out_index = 0.

Configuration
REQ-028 Timeout logic SHALL be compiled in only when macro ABACUS_SNAPSHOT_TIMEOUT_EN is defined.
REQ-029 Without macro: AR and R wait indefinitely; no timeout port exists.
REQ-030 With macro: added output timeout (1 bit, sticky like error); cycle counter cleared on entering AR or R, increments each cycle there; reaching TIMEOUT_CYCLES SHALL set timeout and error, deassert m_arvalid/m_rready, and go to DONE (protocol abandoned; system reset required before slave reuse).

Structure
REQ-031 Shared package abacus_pkg SHALL hold the state enum, AXI response codes (OKAY=2'b00, SLVERR=2'b10), and profiler address offsets (instruction unit +0x100, cache unit +0x200, enables +0x4/+0x8).
REQ-032 No sub-module; single module with one FSM, one index counter, one optional timeout counter.

Verification
REQ-033 NUM_REGS=3, slave always ready, rdata=0x10,0x20,0x30: araddr 0xF0030100/104/108; stream 0x10/0,0x20/1,0x30/2 with out_last only on index 2; done at cycle 10 after start.
REQ-034 out_ready low 5 cycles in OUT for index 1: out_data/out_index stable, no new m_arvalid until handshake.
REQ-035 Second read returns rresp=2'b10: data still streamed, error=1 at done, error=0 after next start.
REQ-036 rst asserted while in R with rvalid pending: next cycle all outputs 0, state IDLE; subsequent start produces clean snapshot from index 0.
REQ-037 start held high continuously: exactly one snapshot per IDLE visit; start pulses while busy produce no extra reads.
REQ-038 With ABACUS_SNAPSHOT_TIMEOUT_EN, TIMEOUT_CYCLES=8, arready never asserted: timeout=1, error=1, done pulse 8 cycles after entering AR, m_arvalid=0 afterwards.
